l1_splice_loader: RTL and testbench
===================================

// Module: l1_splice_loader
// PURPOSE
//  Sequencer for the 24-byte L1 register splice bank. Takes a framed byte
//  stream (valid/ready) from the UART/AHB bridge and turns it into indexed
//  byte writes (wr_data/wr_sel/wr_en) into the bank. Detects frames, checks
//  integrity, times out stalled transfers and reports completion or error.
// PARAMETERS
//  NUM_BYTES  24      payload bytes per frame = bank depth (1..32)
//  SEL_W      5       width of wr_sel; 2**SEL_W >= NUM_BYTES
//  HEADER     8'hA5   frame start byte
//  TIMEOUT    1024    max idle cycles between bytes inside a frame (>=2)
// PORTS
//  clk      in   1      clock, all logic on rising edge
//  rst      in   1      asynchronous reset, active-high
//  s_valid  in   1      input byte valid
//  s_data   in   8      input byte
//  s_ready  out  1      block can accept s_data this cycle
//  abort    in   1      synchronous abort of current frame
//  wr_data  out  8      byte to bank
//  wr_sel   out  SEL_W  bank byte index
//  wr_en    out  1      one-cycle write strobe to bank
//  busy     out  1      frame in progress (state != IDLE)
//  done     out  1      one-cycle pulse: frame loaded and accepted
//  err      out  1      one-cycle pulse: checksum mismatch or timeout
// BEHAVIOUR
//  - Reset: state=IDLE; s_ready=1, wr_data=0, wr_sel=0, wr_en=0, busy=0,
//    done=0, err=0; index, checksum, timer cleared. Reset mid-frame leaves
//    already-written bank bytes untouched.
//  - Accept = s_valid & s_ready. s_ready=1 in IDLE/LOAD/CHECK, 0 in DONE
//    and in any cycle abort=1.
//  - States: IDLE -> LOAD -> [CHECK] -> DONE -> IDLE.
//    IDLE: accepted HEADER -> LOAD, idx=0, csum=0. Other bytes dropped.
//    LOAD: each accepted byte b: registered write next cycle (wr_en=1,
//      wr_data=b, wr_sel=idx); idx++, csum^=b. After byte NUM_BYTES-1 ->
//      CHECK (CHKSUM_EN) else DONE. A HEADER value in LOAD is payload.
//    CHECK: accepted byte == csum -> DONE; else err pulse, -> IDLE.
//    DONE: done=1 for exactly this cycle, -> IDLE.
//  - Latency: accept of last payload byte at cycle N -> its wr_en at N+1;
//    without CHKSUM_EN done at N+1 (coincides with last wr_en); with
//    CHKSUM_EN done one cycle after checksum accept.
//  - Timeout: timer clears on every accept; counts in LOAD/CHECK only;
//    reaching TIMEOUT idle cycles -> err pulse, -> IDLE. No timeout in IDLE.
//  - abort: highest priority after rst; any state -> IDLE next cycle, no
//    err, no done, no accept that cycle. Writes already issued stand.
//  - done and err never assert together; wr_en never asserts in IDLE entry
//    cycle after abort/timeout.
//  - idx never exceeds NUM_BYTES-1; no wrap within a frame.
// CONFIGURATION
//  L1_LOADER_CHKSUM_EN defined: CHECK state present; frame = HEADER +
//    NUM_BYTES payload + 1 XOR checksum byte; mismatch -> err, no done.
//  Not defined: no CHECK state, no csum logic; frame = HEADER + payload;
//    done follows last payload byte. Timeout applies in both builds.
// TESTING
//  1 Reset: rst=1 mid-LOAD (idx=7) -> all outputs reset values, busy=0,
//    next HEADER restarts at wr_sel=0.
//  2 Back-to-back frame A5,00..17 (+csum 0x00 if EN), s_valid=1 every
//    cycle -> 24 wr_en pulses, wr_sel 0..23, wr_data=wr_sel, one done.
//  3 Garbage 3C,5A then A5 + payload -> 3C/5A dropped, no wr_en before
//    frame, writes start at wr_sel=0.
//  4 (EN) payload all 0x11 (csum 0x00), send checksum 0x01 -> 24 writes,
//    err=1 one cycle, done=0, state IDLE.
//  5 Stall after 10 payload bytes for TIMEOUT cycles -> err pulse exactly
//    TIMEOUT cycles after last accept, busy=0; TIMEOUT-1 stall -> no err.
//  6 abort=1 with s_valid=1 at payload byte 5 -> s_ready=0, no wr_en for
//    that byte, no err/done, busy=0 next cycle.

Source files
------------

// File: rtl/l1_splice_loader.sv
// l1_splice_loader: framed byte stream -> indexed L1 splice bank writes.
// Define L1_LOADER_CHKSUM_EN to add the trailing XOR checksum byte stage.
module l1_splice_loader #(
  parameter int         NUM_BYTES = 24,
  parameter int         SEL_W     = 5,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  input  logic             abort,
  output logic [7:0]       wr_data,
  output logic [SEL_W-1:0] wr_sel,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] I_LAST = SEL_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
  logic             wr_en_q, wr_en_d;
  logic             err_q, err_d;
`ifdef L1_LOADER_CHKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic acc;
  logic tmo;

  // Handshake: stall in DONE and whenever an abort is pending.
  assign s_ready = !abort && (state_q != S_DONE);
  assign acc     = s_valid && s_ready;
  assign tmo     = !acc && (timer_q == T_LAST);

  assign wr_data = wr_data_q;
  assign wr_sel  = wr_sel_q;
  assign wr_en   = wr_en_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) && !abort;
  assign err     = err_q;

  // Next-state, write staging, checksum and idle-timer logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_sel_d  = wr_sel_q;
    err_d     = 1'b0;
`ifdef L1_LOADER_CHKSUM_EN
    csum_d    = csum_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (acc && (s_data == HEADER)) begin
            state_d = S_LOAD;
            idx_d   = '0;
`ifdef L1_LOADER_CHKSUM_EN
            csum_d  = '0;
`endif
          end
        end
        S_LOAD: begin
          if (acc) begin
            wr_en_d   = 1'b1;
            wr_data_d = s_data;
            wr_sel_d  = idx_q;
`ifdef L1_LOADER_CHKSUM_EN
            csum_d    = csum_q ^ s_data;
`endif
            if (idx_q == I_LAST) begin
`ifdef L1_LOADER_CHKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (tmo) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`ifdef L1_LOADER_CHKSUM_EN
        S_CHECK: begin
          if (acc) begin
            if (s_data == csum_q) begin
              state_d = S_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else if (tmo) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef L1_LOADER_CHKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
`ifdef L1_LOADER_CHKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_l1_splice_loader.sv
// tb_l1_splice_loader: scoreboard bench for the L1 splice loader.
// Writes and done/err events are queued by stimulus, popped by a monitor.
module tb_l1_splice_loader;

  localparam int NB = 24;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       abort = 1'b0;
  logic       s_ready;
  logic [7:0] wr_data;
  logic [4:0] wr_sel;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr = 0;

  logic [15:0] wq[$];
  logic [1:0]  eq[$];
  logic [15:0] w_m;
  logic [1:0]  e_m;
  logic [7:0]  ck_m;
  logic [7:0]  pay[NB];

  l1_splice_loader #(
    .NUM_BYTES(NB),
    .SEL_W(5),
    .HEADER(8'hA5),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .abort(abort),
    .wr_data(wr_data),
    .wr_sel(wr_sel),
    .wr_en(wr_en),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected writes and events whenever the DUT shows one.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        last_wr = cyc;
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_unexpected: got sel %0d data %0h, expected none",
                   wr_sel, wr_data);
        end else begin
          w_m = wq.pop_front();
          chk("wr_sel", 32'(wr_sel), 32'(w_m[15:8]));
          chk("wr_data", 32'(wr_data), 32'(w_m[7:0]));
        end
      end
      if (done || err) begin
        if (eq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL evt_unexpected: got done=%0b err=%0b, expected none",
                   done, err);
        end else begin
          e_m = eq.pop_front();
          chk("event", 32'({done, err}), 32'(e_m));
`ifndef L1_LOADER_CHKSUM_EN
          if (done) chk("done_with_last_wr", cyc, last_wr);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_hdr();
    ck_m = 8'h00;
    send(8'hA5);
  endtask

  task automatic send_pay(input int from, input int to);
    for (int i = from; i < to; i++) begin
      wq.push_back({8'(i), pay[i]});
      ck_m = ck_m ^ pay[i];
      send(pay[i]);
    end
  endtask

  task automatic finish_frame(input bit bad);
`ifdef L1_LOADER_CHKSUM_EN
    eq.push_back(bad ? 2'b01 : 2'b10);
    send(bad ? (ck_m ^ 8'h01) : ck_m);
`else
    if (!bad) eq.push_back(2'b10);
`endif
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_wr_sel"}, 32'(wr_sel), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  int  acc_c;
  bit  seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;
    tick();

    // Reset in the middle of a frame (idx=7).
    for (int i = 0; i < NB; i++) pay[i] = 8'(8'h40 + i);
    send_hdr();
    send_pay(0, 7);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Back-to-back frame, data == index.
    for (int i = 0; i < NB; i++) pay[i] = 8'(i);
    send_hdr();
    send_pay(0, NB);
    finish_frame(1'b0);
    tick();

    // Garbage ahead of a frame; HEADER value inside payload.
    send(8'h3C);
    send(8'h5A);
    for (int i = 0; i < NB; i++) pay[i] = 8'(8'h80 + i);
    pay[3] = 8'hA5;
    send_hdr();
    send_pay(0, NB);
    finish_frame(1'b0);
    tick();

`ifdef L1_LOADER_CHKSUM_EN
    // Bad checksum.
    for (int i = 0; i < NB; i++) pay[i] = 8'h11;
    send_hdr();
    send_pay(0, NB);
    finish_frame(1'b1);
    @(negedge clk);
    chk("badck_busy", 32'(busy), 0);
    chk("badck_done", 32'(done), 0);
    tick();
`endif

    // Stall of TO-1 cycles mid frame: no timeout.
    for (int i = 0; i < NB; i++) pay[i] = 8'(8'hC0 + i);
    send_hdr();
    send_pay(0, 10);
    repeat (TO - 1) tick();
    send_pay(10, NB);
    finish_frame(1'b0);
    tick();

    // Stall of TO cycles: err exactly TO cycles after the last accept.
    send_hdr();
    send_pay(0, 10);
    acc_c = cyc;
    eq.push_back(2'b01);
    seen = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clk);
      if (err && !seen) begin
        seen = 1'b1;
        chk("tmo_latency", cyc - acc_c, TO);
        chk("tmo_busy", 32'(busy), 0);
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL tmo_err: got no err within %0d cycles, expected err", TO + 4);
    end
    tick();

    // Abort at payload byte 5.
    for (int i = 0; i < NB; i++) pay[i] = 8'(8'h20 + i);
    send_hdr();
    send_pay(0, 5);
    s_valid = 1'b1;
    s_data  = pay[5];
    abort   = 1'b1;
    #1 chk("abort_s_ready", 32'(s_ready), 0);
    chk("abort_done", 32'(done), 0);
    @(posedge clk);
    #1 abort = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    tick();

    // Fresh frame after abort starts at index 0.
    send_hdr();
    send_pay(0, NB);
    finish_frame(1'b0);

    repeat (4) tick();
    chk("wq_empty", wq.size(), 0);
    chk("eq_empty", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
